// File: rtl/fpu_pkg.sv
// fpu_pkg: shared FPU field widths, special constants and the sequential subtractor FSM encoding
package fpu_pkg;
    localparam int EXPONENT_LENGTH = 8;
    localparam int MANTISSA_LENGTH = 23;
    localparam logic [31:0] QNAN = 32'h7FC00000;
    localparam logic [EXPONENT_LENGTH-1:0] EXP_ONES = '1;
    typedef enum logic [2:0] {IDLE, UNPACK, ALIGN, ADD, NORM, PACK, DONE} state_t;
endpackage

// File: rtl/fpu_unpack.sv
// fpu_unpack: splits an IEEE-754 word into fields, classifies it and restores the hidden bit
// Subnormals are flushed: a zero exponent yields a zero mantissa.
module fpu_unpack #(
    parameter int EXPONENT_LENGTH = fpu_pkg::EXPONENT_LENGTH,
    parameter int MANTISSA_LENGTH = fpu_pkg::MANTISSA_LENGTH
) (
    input  logic [EXPONENT_LENGTH+MANTISSA_LENGTH:0] word,
    output logic                                     sign,
    output logic [EXPONENT_LENGTH-1:0]               exp,
    output logic [MANTISSA_LENGTH:0]                 mant,
    output logic                                     is_zero,
    output logic                                     is_inf,
    output logic                                     is_nan
);
    import fpu_pkg::*;
    localparam int EL = EXPONENT_LENGTH;
    localparam int ML = MANTISSA_LENGTH;
    always_comb begin
        sign = word[EL+ML];
        exp = word[EL+ML-1:ML];
        is_zero = exp == '0;
        is_inf = exp == '1 && word[ML-1:0] == '0;
        is_nan = exp == '1 && word[ML-1:0] != '0;
        mant = is_zero ? '0 : {1'b1, word[ML-1:0]};
    end
endmodule

// File: rtl/fpu_sub_seq.sv
// fpu_sub_seq: iterative IEEE-754 subtractor (Diff = A - B) with valid/ready handshake
// Define FPU_SUB_ADD_MODE_EN to add the op port (op=1 subtract, op=0 add).
module fpu_sub_seq #(
    parameter int EXPONENT_LENGTH = fpu_pkg::EXPONENT_LENGTH,
    parameter int MANTISSA_LENGTH = fpu_pkg::MANTISSA_LENGTH,
    localparam int W = EXPONENT_LENGTH + MANTISSA_LENGTH + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
`ifdef FPU_SUB_ADD_MODE_EN
    input  logic         op,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] Diff,
    output logic         overflow,
    output logic         underflow,
    output logic         exception
);
    import fpu_pkg::*;
    localparam int EL = EXPONENT_LENGTH;
    localparam int ML = MANTISSA_LENGTH;
    localparam logic [W-1:0] NAN_W = (W == 32) ? W'(QNAN) : {1'b0, {EL{1'b1}}, 1'b1, {(ML-1){1'b0}}};
    localparam logic [EL:0] E_MAX = {1'b0, {EL{1'b1}}};
    state_t state;
    logic [W-1:0] a_q, b_q;
    logic sx, exc, unf, zr;
    logic [EL:0] ex;
    logic [ML:0] mx, my;
    logic [EL-1:0] d;
    logic [ML+1:0] sum;
    logic sa, sb, za, zb, ia, ib, na, nb, a_ge, neg_b, special;
    logic [EL-1:0] ea, eb;
    logic [ML:0] ma, mb;
    fpu_unpack #(.EXPONENT_LENGTH(EL), .MANTISSA_LENGTH(ML)) u_a (
        .word(a_q), .sign(sa), .exp(ea), .mant(ma), .is_zero(za), .is_inf(ia), .is_nan(na)
    );
    fpu_unpack #(.EXPONENT_LENGTH(EL), .MANTISSA_LENGTH(ML)) u_b (
        .word(b_q), .sign(sb), .exp(eb), .mant(mb), .is_zero(zb), .is_inf(ib), .is_nan(nb)
    );
    assign in_ready = state == IDLE;
    assign a_ge = {ea, ma} >= {eb, mb};
    assign special = ia | ib | na | nb;
`ifdef FPU_SUB_ADD_MODE_EN
    assign neg_b = op ? ~B[W-1] : B[W-1];
`else
    assign neg_b = ~B[W-1];
`endif
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            out_valid <= 1'b0;
            Diff <= '0;
            overflow <= 1'b0;
            underflow <= 1'b0;
            exception <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_q <= A;
                    b_q <= {neg_b, B[W-2:0]};
                    state <= UNPACK;
                end
                UNPACK: begin
                    exc <= special;
                    unf <= 1'b0;
                    zr <= 1'b0;
                    sx <= a_ge ? sa : sb;
                    ex <= {1'b0, a_ge ? ea : eb};
                    mx <= a_ge ? ma : mb;
                    my <= a_ge ? mb : ma;
                    // a zero smaller operand needs no alignment
                    d <= (a_ge ? zb : za) ? '0 : a_ge ? ea - eb : eb - ea;
                    state <= special ? PACK : ALIGN;
                end
                ALIGN: begin
                    if (d > EL'(ML + 1)) begin
                        my <= '0;
                        d <= '0;
                    end else if (d == '0) state <= ADD;
                    else begin
                        my <= my >> 1;
                        d <= d - 1'b1;
                    end
                end
                ADD: begin
                    sum <= (sa ^ sb) ? {1'b0, mx} - {1'b0, my} : {1'b0, mx} + {1'b0, my};
                    state <= NORM;
                end
                NORM: begin
                    if (sum[ML+1]) begin
                        sum <= sum >> 1;
                        ex <= ex + 1'b1;
                        state <= PACK;
                    end else if (sum == '0) begin
                        zr <= 1'b1;
                        state <= PACK;
                    end else if (!sum[ML]) begin
                        if (ex == (EL+1)'(1)) begin
                            unf <= 1'b1;
                            state <= PACK;
                        end else begin
                            sum <= sum << 1;
                            ex <= ex - 1'b1;
                        end
                    end else state <= PACK;
                end
                PACK: begin
                    exception <= exc;
                    underflow <= !exc && unf;
                    overflow <= !exc && !unf && !zr && ex >= E_MAX;
                    Diff <= exc ? NAN_W
                          : unf ? {sx, {(W-1){1'b0}}}
                          : zr ? '0
                          : ex >= E_MAX ? {sx, {EL{1'b1}}, {ML{1'b0}}}
                          : {sx, ex[EL-1:0], sum[ML-1:0]};
                    out_valid <= 1'b1;
                    state <= DONE;
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fpu_sub_seq.sv
// tb_fpu_sub_seq: directed-vector bench for fpu_sub_seq with hand-computed results
module tb_fpu_sub_seq;
    logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [31:0] A = '0, B = '0;
    logic in_ready, out_valid, overflow, underflow, exception;
    logic [31:0] Diff;
    int tests = 0, fails = 0;

    fpu_sub_seq dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B),
`ifdef FPU_SUB_ADD_MODE_EN
        .op(1'b1),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .Diff(Diff),
        .overflow(overflow), .underflow(underflow), .exception(exception)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!out_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
        check({tag, "/valid"}, 32'(out_valid), 32'd1);
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        A = a;
        B = b;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic accept();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ed, input logic [2:0] ef);
        check({tag, "/ready"}, 32'(in_ready), 32'd1);
        issue(a, b);
        wait_valid(tag);
        check({tag, "/diff"}, Diff, ed);
        check({tag, "/flags"}, {29'b0, overflow, underflow, exception}, {29'b0, ef});
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst/ready", 32'(in_ready), 32'd1);
        check("rst/valid", 32'(out_valid), 32'd0);
        check("rst/diff", Diff, 32'h0);
        check("rst/flags", {29'b0, overflow, underflow, exception}, 32'h0);
        rst_n = 1'b1;

        run("6.25-3.125", 32'h40C80000, 32'h40480000, 32'h40480000, 3'b000);
        accept();

        @(negedge clk);
        A = 32'h40F40000;
        B = 32'h40A40000;
        in_valid = 1'b1;
        @(negedge clk);
        A = 32'h3E400000;
        B = 32'h3E000000;
        check("b2b/busy", 32'(in_ready), 32'd0);
        wait_valid("b2b1");
        check("b2b1/diff", Diff, 32'h40200000);
        accept();
        check("b2b1/hold", Diff, 32'h40200000);
        check("b2b1/idle", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        wait_valid("b2b2");
        check("b2b2/diff", Diff, 32'h3D800000);
        check("b2b2/flags", {29'b0, overflow, underflow, exception}, 32'h0);
        accept();

        run("equal", 32'h40A80000, 32'h40A80000, 32'h00000000, 3'b000);
        accept();
        run("ovf", 32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000, 3'b100);
        accept();
        run("unf", 32'h00800000, 32'h00800001, 32'h80000000, 3'b010);
        accept();
        run("inf", 32'h7F800000, 32'h3F800000, 32'h7FC00000, 3'b001);
        repeat (10) begin
            @(negedge clk);
            check("hold/valid", 32'(out_valid), 32'd1);
            check("hold/diff", Diff, 32'h7FC00000);
        end
        accept();

        issue(32'h4B000000, 32'h3F800000);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst/ready", 32'(in_ready), 32'd1);
        check("midrst/valid", 32'(out_valid), 32'd0);
        check("midrst/diff", Diff, 32'h0);
        check("midrst/flags", {29'b0, overflow, underflow, exception}, 32'h0);
        run("fresh", 32'h4B000000, 32'h3F800000, 32'h4AFFFFFE, 3'b000);
        accept();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
